// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between the icache and dcache, one full-line
// transaction at a time, with round-robin tie-break and a sticky response watchdog.
//
// state    | meaning
// ---------+---------------------------------------------------
// S_IDLE   | no transaction; arbitrate pending requests
// S_I_BUSY | icache line read outstanding on pmem
// S_D_BUSY | dcache line read or write outstanding on pmem
// S_DONE_I | one-cycle i_resp, i_rdata valid
// S_DONE_D | one-cycle d_resp, d_rdata valid
module pmem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 256,
   parameter int TIMEOUT = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_read,
   input  logic [ADDR_W-1:0]   i_address,
   output logic [LINE_W-1:0]   i_rdata,
   output logic                i_resp,
   input  logic                d_read,
   input  logic                d_write,
   input  logic [ADDR_W-1:0]   d_address,
   input  logic [LINE_W-1:0]   d_wdata,
   input  logic [LINE_W/8-1:0] d_byte_enable,
   output logic [LINE_W-1:0]   d_rdata,
   output logic                d_resp,
   output logic                mem_read,
   output logic                mem_write,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [LINE_W-1:0]   mem_wdata,
   output logic [LINE_W/8-1:0] mem_byte_enable,
   input  logic [LINE_W-1:0]   mem_rdata,
   input  logic                mem_resp,
   output logic                err
);

   localparam int BE_W  = LINE_W / 8;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_I_BUSY,
      S_D_BUSY,
      S_DONE_I,
      S_DONE_D
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_last_d;
   logic [ADDR_W-1:0]   r_addr;
   logic [LINE_W-1:0]   r_wdata;
   logic [BE_W-1:0]     r_be;
   logic                r_op_wr;
   logic [LINE_W-1:0]   r_i_rdata;
   logic [LINE_W-1:0]   r_d_rdata;
   logic [CNT_W-1:0]    r_wd_cnt;
   logic                r_err;

   logic                w_req_i;
   logic                w_req_d;
   logic                w_grant_i;
   logic                w_grant_d;
   logic                w_busy;
   logic [CNT_W-1:0]    w_cnt_inc;

   always_comb begin
      w_req_i     = i_read;
      w_req_d     = d_read | d_write;
      w_grant_i   = 1'b0;
      w_grant_d   = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            // on a tie the requester that did not win last time goes first
            if (w_req_i && (!w_req_d || r_last_d)) begin
               w_grant_i   = 1'b1;
               w_state_nxt = S_I_BUSY;
            end else if (w_req_d) begin
               w_grant_d   = 1'b1;
               w_state_nxt = S_D_BUSY;
            end
         end
         S_I_BUSY: if (mem_resp) w_state_nxt = S_DONE_I;
         S_D_BUSY: if (mem_resp) w_state_nxt = S_DONE_D;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   assign w_busy    = (r_state == S_I_BUSY) || (r_state == S_D_BUSY);
   assign w_cnt_inc = r_wd_cnt + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_d  <= 1'b1;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_be      <= '0;
         r_op_wr   <= 1'b0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         if (w_grant_i) begin
            r_addr   <= i_address;
            r_wdata  <= '0;
            r_be     <= '0;
            r_op_wr  <= 1'b0;
            r_last_d <= 1'b0;
         end else if (w_grant_d) begin
            r_addr   <= d_address;
            r_wdata  <= d_wdata;
            r_be     <= d_byte_enable;
            r_op_wr  <= d_write;
            r_last_d <= 1'b1;
         end
         if (mem_resp && (r_state == S_I_BUSY))
            r_i_rdata <= mem_rdata;
         if (mem_resp && (r_state == S_D_BUSY) && !r_op_wr)
            r_d_rdata <= mem_rdata;
      end
   end

   // saturating busy-cycle count; err latches once TIMEOUT cycles pass unanswered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wd_cnt <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_grant_i || w_grant_d)
            r_wd_cnt <= '0;
         else if (w_busy && (r_wd_cnt != CNT_MAX))
            r_wd_cnt <= w_cnt_inc;
         if ((TIMEOUT != 0) && w_busy && !mem_resp && (w_cnt_inc == CNT_MAX))
            r_err <= 1'b1;
      end
   end

   assign mem_read        = (r_state == S_I_BUSY) || ((r_state == S_D_BUSY) && !r_op_wr);
   assign mem_write       = (r_state == S_D_BUSY) && r_op_wr;
   assign mem_address     = r_addr;
   assign mem_wdata       = r_wdata;
   assign mem_byte_enable = r_be;
   assign i_resp          = (r_state == S_DONE_I);
   assign d_resp          = (r_state == S_DONE_D);
   assign i_rdata         = r_i_rdata;
   assign d_rdata         = r_d_rdata;
   assign err             = r_err;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Random and directed transactions against a transaction-level model of the
// icache/dcache pmem arbiter (round-robin grant, line capture, watchdog).
`timescale 1ns/1ps
module tb_pmem_arbiter;

   localparam int ADDR_W  = 32;
   localparam int LINE_W  = 256;
   localparam int BE_W    = LINE_W / 8;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              i_read;
   logic [ADDR_W-1:0] i_address;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_address;
   logic [LINE_W-1:0] d_wdata;
   logic [BE_W-1:0]   d_byte_enable;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [LINE_W-1:0] mem_wdata;
   logic [BE_W-1:0]   mem_byte_enable;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_resp;
   logic              err;

   pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp), .err(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   bit                mdl_last_d;
   bit                mdl_err;
   logic [LINE_W-1:0] mdl_i_rdata;
   logic [LINE_W-1:0] mdl_d_rdata;

   task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] rnd_line();
      logic [LINE_W-1:0] r;
      r = '0;
      for (int i = 0; i < LINE_W / 32; i++) r = {r[LINE_W-33:0], 32'($urandom())};
      return r;
   endfunction

   task automatic new_reqs(input int mode);
      if (mode == 1) begin
         i_read = 1'b1; d_read = 1'b1; d_write = 1'b0;
      end else begin
         i_read  = ($urandom_range(0, 3) != 0);
         d_read  = 1'($urandom_range(0, 1));
         d_write = 1'($urandom_range(0, 1));
      end
      i_address     = $urandom();
      d_address     = $urandom();
      d_wdata       = rnd_line();
      d_byte_enable = $urandom();
   endtask

   task automatic model_reset();
      mdl_last_d  = 1'b1;
      mdl_err     = 1'b0;
      mdl_i_rdata = '0;
      mdl_d_rdata = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_read"},  mem_read, 0);
      chk({tag, "_mem_write"}, mem_write, 0);
      chk({tag, "_mem_addr"},  mem_address, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_mem_be"},    mem_byte_enable, 0);
      chk({tag, "_i_resp"},    i_resp, 0);
      chk({tag, "_d_resp"},    d_resp, 0);
      chk({tag, "_i_rdata"},   i_rdata, 0);
      chk({tag, "_d_rdata"},   d_rdata, 0);
      chk({tag, "_err"},       err, 0);
   endtask

   // Entered at a falling edge with the DUT idle and requests driven for this cycle.
   task automatic xact(input int lat, input logic [LINE_W-1:0] rd);
      bit                g_i, g_d, wr;
      logic [ADDR_W-1:0] ea;
      logic [LINE_W-1:0] ew;
      logic [BE_W-1:0]   eb;
      chk("idle_mem_read", mem_read, 0);
      chk("idle_mem_write", mem_write, 0);
      chk("idle_i_resp", i_resp, 0);
      chk("idle_d_resp", d_resp, 0);
      g_i = i_read && (!(d_read || d_write) || mdl_last_d);
      g_d = !g_i && (d_read || d_write);
      wr  = g_d && d_write;
      ea  = g_i ? i_address : d_address;
      ew  = g_d ? d_wdata : '0;
      eb  = g_d ? d_byte_enable : '0;
      if (g_i || g_d) mdl_last_d = g_d;
      mem_resp  = ($urandom_range(0, 3) == 0);
      mem_rdata = rnd_line();
      @(negedge clk);
      mem_resp = 1'b0;
      if (!g_i && !g_d) begin
         chk("nogrant_mem_read", mem_read, 0);
         chk("nogrant_mem_write", mem_write, 0);
         chk("nogrant_i_resp", i_resp, 0);
         chk("nogrant_d_resp", d_resp, 0);
         new_reqs(0);
         return;
      end
      for (int k = 1; k <= lat; k++) begin
         chk("busy_mem_read", mem_read, !wr);
         chk("busy_mem_write", mem_write, wr);
         chk("busy_mem_addr", mem_address, ea);
         chk("busy_mem_wdata", mem_wdata, ew);
         chk("busy_mem_be", mem_byte_enable, eb);
         chk("busy_i_resp", i_resp, 0);
         chk("busy_d_resp", d_resp, 0);
         chk("busy_err", err, mdl_err || (k - 1 >= TIMEOUT));
         if ($urandom_range(0, 2) == 0) new_reqs(0);
         if (k == lat) begin
            mem_resp  = 1'b1;
            mem_rdata = rd;
         end
         @(negedge clk);
      end
      mem_resp  = 1'b0;
      mem_rdata = rnd_line();
      if (lat - 1 >= TIMEOUT) mdl_err = 1'b1;
      if (!wr) begin
         if (g_i) mdl_i_rdata = rd;
         else     mdl_d_rdata = rd;
      end
      chk("done_mem_read", mem_read, 0);
      chk("done_mem_write", mem_write, 0);
      chk("done_i_resp", i_resp, g_i);
      chk("done_d_resp", d_resp, g_d);
      chk("done_i_rdata", i_rdata, mdl_i_rdata);
      chk("done_d_rdata", d_rdata, mdl_d_rdata);
      chk("done_err", err, mdl_err);
      new_reqs(0);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b1;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      i_address = '0; d_address = '0; d_wdata = '0; d_byte_enable = '0;
      mem_rdata = '0; mem_resp = 1'b0;
      model_reset();
      #2 rst_n = 1'b0;
      #1 chk_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // icache line read, 8-cycle pmem
      i_read = 1'b1; i_address = 32'h0000_1000; d_read = 1'b0; d_write = 1'b0;
      xact(8, {32{8'hA5}});

      // dcache full-line write
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b1;
      d_address = 32'h0000_2000; d_wdata = {8{32'h1234_5678}}; d_byte_enable = 32'hFFFF_FFFF;
      xact(4, rnd_line());

      // both requesters saturating: grants must alternate
      for (int n = 0; n < 4; n++) begin
         new_reqs(1);
         xact(int'($urandom_range(1, 3)), rnd_line());
      end

      // read and write together: write wins
      i_read = 1'b0; d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_0040;
      xact(2, rnd_line());

      new_reqs(0);
      repeat (200) xact(int'($urandom_range(1, 6)), rnd_line());

      // withheld response trips the watchdog; late response still completes
      i_read = 1'b0; d_read = 1'b1; d_write = 1'b0;
      xact(20, rnd_line());
      i_read = 1'b1; d_read = 1'b0; d_write = 1'b0;
      xact(3, rnd_line());

      // reset in the middle of a transaction
      i_read = 1'b1; d_read = 1'b0; d_write = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1 chk_all_zero("midreset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      new_reqs(1);
      xact(3, rnd_line());

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Arbitrates the single physical-memory path (cacheline adaptor / pmem) between the instruction cache and the data cache.
- Accepts one full-line request at a time from either requester and latches its address, write data and byte enables.
- Drives the downstream read/write strobes until the downstream side responds, then returns the line and a one-cycle response to the granted requester.
- Breaks ties round-robin and flags responses that never arrive.

Parameters:
ADDR_W, 32, address width
LINE_W, 256, cache line width in bits
TIMEOUT, 1024, cycles to wait for mem_resp before raising err; 0 disables the watchdog

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_read  in  1  icache line read request
i_address  in  ADDR_W  icache line address
i_rdata  out  LINE_W  line returned to icache
i_resp  out  1  icache response, one-cycle pulse
d_read  in  1  dcache line read request
d_write  in  1  dcache line write request
d_address  in  ADDR_W  dcache line address
d_wdata  in  LINE_W  dcache write line
d_byte_enable  in  LINE_W/8  dcache byte enables
d_rdata  out  LINE_W  line returned to dcache
d_resp  out  1  dcache response, one-cycle pulse
mem_read  out  1  downstream read strobe
mem_write  out  1  downstream write strobe
mem_address  out  ADDR_W  downstream address
mem_wdata  out  LINE_W  downstream write line
mem_byte_enable  out  LINE_W/8  downstream byte enables
mem_rdata  in  LINE_W  downstream read line
mem_resp  in  1  downstream completion, one-cycle pulse
err  out  1  sticky watchdog timeout flag

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All outputs 0 (including rdata registers and err).
  - State is IDLE.
  - last_grant = D, so the icache wins the first tie.
- States: IDLE, I_BUSY, D_BUSY, DONE_I, DONE_D.
- IDLE:
  - Evaluate requests: req_i = i_read; req_d = d_read | d_write.
  - Only one requesting: grant it.
  - Both requesting: grant the one that is not last_grant.
  - On grant, latch address; for D also latch wdata, byte_enable and the op. If d_read and d_write are both high, write wins.
  - Update last_grant and go to I_BUSY or D_BUSY.
  - Neither requesting: stay in IDLE.
- I_BUSY / D_BUSY:
  - mem_read or mem_write is driven from registered state, high from the cycle after the grant until mem_resp is sampled high.
  - mem_address, mem_wdata and mem_byte_enable hold the latched values.
  - mem_wdata and mem_byte_enable are 0 for icache reads.
- On mem_resp:
  - Capture mem_rdata into the granted requester's rdata register (reads only; writes leave rdata unchanged).
  - Drop both strobes on the same edge.
  - Go to DONE_I or DONE_D.
- DONE_x:
  - x_resp = 1 for exactly one cycle; x_rdata is valid in that cycle and held until the next capture.
  - The requester deasserts its request on the edge following resp.
  - Next state is IDLE; no new grant is made in the DONE cycle.
- Latency: a request seen in IDLE at cycle N produces a strobe at N+1. mem_resp at cycle M produces x_resp at M+1. Minimum round trip with a same-cycle pmem is 3 cycles.
- Request changes while BUSY are ignored. A request deasserted mid-transaction does not abort it.
- mem_resp sampled in IDLE or DONE is ignored.
- Watchdog:
  - A counter clears on grant and increments each BUSY cycle.
  - When the count reaches TIMEOUT with no mem_resp, err sets and stays set until reset; the transaction keeps waiting.
  - The counter saturates and does not wrap.
- Reset mid-transaction:
  - Strobes and resp drop immediately (async).
  - The latched request and rdata are lost.

Test Plan:
- i_read=1, i_address=0x0000_1000, pmem responds after 8 cycles with mem_rdata=0xA5…A5 -> mem_read high cycles 1–8, mem_address=0x1000, i_resp pulses once at cycle 9 with i_rdata=0xA5…A5, d_resp stays 0.
- d_write=1, d_address=0x2000, d_wdata=0x1234…, d_byte_enable=0xFFFF_FFFF -> mem_write high with those values held stable until mem_resp, d_resp one pulse, d_rdata unchanged.
- i_read and d_read both asserted from reset, each re-requesting back-to-back -> grant order I, D, I, D; no cycle with mem_read and mem_write both high.
- d_read=d_write=1 with d_address=0x40 -> mem_write=1, mem_read=0.
- Spurious mem_resp in IDLE, plus i_address changed to 0x3000 mid-I_BUSY -> no resp pulse, mem_address stays at the latched 0x1000.
- TIMEOUT=16, mem_resp withheld -> err=1 at the 16th BUSY cycle; late mem_resp still completes the transaction with err still 1. rst_n pulse low mid-BUSY -> all outputs 0 asynchronously, state IDLE.
